fetch_stage: RTL

Fetch stage of the MINI-RISC pipeline, directly upstream of the F/D pipeline register. It owns the 11-bit fetch PC and issues in-order requests to a variable-latency instruction memory. Returned words are held with their PCs in a small prefetch buffer. The head entry is presented as `instruction_out`/`pc_out`; branch redirects from Execute discard all fetched and in-flight work.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle between fetch and imem
interface fetch_stage_if #(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    // Fetch stage drives requests and receives responses
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Instruction memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MINI-RISC fetch stage with credit-limited prefetch buffer
module fetch_stage #(
    parameter int PC_W     = 11,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_F,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_addr,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
);
    // DEPTH is a power of two, so pointers wrap naturally; counters need one extra bit to hold DEPTH
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    fpc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   count;

    // PCs of requests accepted by memory but not yet answered
    logic [PC_W-1:0]    pcq_mem [DEPTH];
    logic [PTR_W-1:0]   pcq_wr;
    logic [PTR_W-1:0]   pcq_rd;

    // Prefetch buffer of returned {instr, pc} pairs
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [PC_W-1:0]    fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   fifo_wr;
    logic [PTR_W-1:0]   fifo_rd;

    logic [CNT_W:0]     credits_used;
    logic               accept;
    logic               resp;
    logic               resp_keep;
    logic               resp_drop;
    logic               pop;

    // Buffered plus outstanding work may never exceed DEPTH, which keeps the FIFO from overflowing
    assign credits_used  = {1'b0, outstanding} + {1'b0, count};
    assign imem.imem_req = !reset && !redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));
    assign imem.imem_addr = fpc;

    assign accept    = imem.imem_req && imem.imem_ready;
    // A response with nothing outstanding is spurious and ignored entirely
    assign resp      = imem.imem_rvalid && (outstanding != '0);
    // During a redirect the arriving response is discarded along with everything else
    assign resp_keep = resp && !redirect_valid && (drop_cnt == '0);
    assign resp_drop = resp && !redirect_valid && (drop_cnt != '0);

    assign instr_valid     = (count != '0) && !redirect_valid;
    assign pop             = instr_valid && !stall_F;
    assign instruction_out = instr_valid ? fifo_instr[fifo_rd] : '0;
    assign pc_out          = instr_valid ? fifo_pc[fifo_rd] : '0;

    // Control state: fetch PC, credit counters, drop counter and queue pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc         <= PC_W'(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            if (accept) begin
                fpc    <= fpc + PC_W'(1);
                pcq_wr <= pcq_wr + PTR_W'(1);
            end
            if (resp) begin
                pcq_rd <= pcq_rd + PTR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(resp);

            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path
                fpc      <= redirect_addr;
                drop_cnt <= outstanding - CNT_W'(resp);
                count    <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end else begin
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (resp_keep) begin
                    fifo_wr <= fifo_wr + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PTR_W'(1);
                end
                count <= count + CNT_W'(resp_keep) - CNT_W'(pop);
            end
        end
    end

    // Queue storage; validity is tracked by the pointers and counters, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr] <= fpc;
        end
        if (resp_keep) begin
            fifo_instr[fifo_wr] <= imem.imem_rdata;
            fifo_pc[fifo_wr]    <= pcq_mem[pcq_rd];
        end
    end
endmodule
